solve_sequencer: RTL and testbench

//  Run controller for one sudoku grid solver instance. Accepts a solve request over a

---
 rtl/grid_pkg.sv | 23 ++
 rtl/solve_sequencer_sat_counter.sv | 25 ++
 rtl/solve_sequencer.sv | 167 ++++++++++++++++
 tb/tb_solve_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared grid constants plus the solve status and sequencer state encodings.
package grid_pkg;

  localparam int GRID_ORD  = 3;
  localparam int GRID_LEN  = GRID_ORD * GRID_ORD;
  localparam int GRID_AREA = GRID_LEN * GRID_LEN;

  typedef enum logic [1:0] {
    ST_SOLVED     = 2'd0,
    ST_UNSOLVABLE = 2'd1,
    ST_TIMEOUT    = 2'd2,
    ST_ABORTED    = 2'd3
  } status_e;

  typedef enum logic [4:0] {
    SEQ_IDLE   = 5'b00001,
    SEQ_CLEAR  = 5'b00010,
    SEQ_KICK   = 5'b00100,
    SEQ_RUN    = 5'b01000,
    SEQ_REPORT = 5'b10000
  } seq_state_e;

endpackage

// File: rtl/solve_sequencer_sat_counter.sv
// Saturating up-counter; value_inc is the value the next increment would produce.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic [W-1:0] value_inc
);

  assign value_inc = (&value) ? value : value + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= value_inc;
    end
  end

endmodule

// File: rtl/solve_sequencer.sv
// Run controller for one sudoku grid solver: request, clear, kick, run, report.
// Optional RUN-cycle budget enabled by defining SOLVE_TIMEOUT_EN.
module solve_sequencer
  import grid_pkg::*;
#(
  parameter int CYCLE_W        = 32,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               abort,
  output logic               grid_reset,
  output logic               grid_start,
  input  logic               grid_done_success,
  input  logic               grid_done_failure,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_status,
  output logic [CYCLE_W-1:0] rsp_cycles,
  output logic               busy
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

  if (CLEAR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("solve_sequencer: CLEAR_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  seq_state_e         state_q, state_d;
  logic [CLR_W-1:0]   clr_q;
  status_e            status_q;
  logic [CYCLE_W-1:0] cycles_q;

  logic               cnt_clear, cnt_inc;
  logic [CYCLE_W-1:0] cnt_val, cnt_next;
  logic               timeout_hit;
  logic               clr_load, clr_dec;
  logic               lat_en;
  status_e            lat_status;
  logic [CYCLE_W-1:0] lat_cycles;

  sat_counter #(.W(CYCLE_W)) u_cycle_cnt (
    .clock     (clock),
    .reset     (reset),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .value     (cnt_val),
    .value_inc (cnt_next)
  );

`ifdef SOLVE_TIMEOUT_EN
  localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);
  assign timeout_hit = (cnt_val == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      clr_q    <= '0;
      status_q <= ST_SOLVED;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_load) begin
        clr_q <= CLR_LOAD;
      end else if (clr_dec) begin
        clr_q <= clr_q - 1'b1;
      end
      if (lat_en) begin
        status_q <= lat_status;
        cycles_q <= lat_cycles;
      end
    end
  end

  // Next state, latch strobes and output decode.
  always_comb begin
    state_d    = state_q;
    clr_load   = 1'b0;
    clr_dec    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    lat_en     = 1'b0;
    lat_status = ST_SOLVED;
    lat_cycles = '0;
    req_ready  = 1'b0;
    grid_reset = 1'b1;
    grid_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      SEQ_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          clr_load = 1'b1;
          state_d  = SEQ_CLEAR;
        end
      end
      SEQ_CLEAR: begin
        if (abort) begin
          lat_en     = 1'b1;
          lat_status = ST_ABORTED;
          state_d    = SEQ_REPORT;
        end else if (clr_q == '0) begin
          state_d = SEQ_KICK;
        end else begin
          clr_dec = 1'b1;
        end
      end
      SEQ_KICK: begin
        grid_reset = 1'b0;
        grid_start = 1'b1;
        cnt_clear  = 1'b1;
        if (abort) begin
          lat_en     = 1'b1;
          lat_status = ST_ABORTED;
          state_d    = SEQ_REPORT;
        end else begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        // The latched count includes the exit cycle itself.
        grid_reset = 1'b0;
        cnt_inc    = 1'b1;
        lat_cycles = cnt_next;
        if (grid_done_success) begin
          lat_en     = 1'b1;
          lat_status = ST_SOLVED;
        end else if (grid_done_failure) begin
          lat_en     = 1'b1;
          lat_status = ST_UNSOLVABLE;
        end else if (timeout_hit) begin
          lat_en     = 1'b1;
          lat_status = ST_TIMEOUT;
        end else if (abort) begin
          lat_en     = 1'b1;
          lat_status = ST_ABORTED;
        end
        if (lat_en) begin
          state_d = SEQ_REPORT;
        end
      end
      SEQ_REPORT: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  assign rsp_status = status_q;
  assign rsp_cycles = cycles_q;

endmodule

// File: tb/tb_solve_sequencer.sv
// Randomized scoreboard bench for solve_sequencer with a grid stub and response monitor.
module tb_solve_sequencer;

`ifdef SOLVE_TIMEOUT_EN
  localparam int CW = 8;
`else
  localparam int CW = 4;
`endif
  localparam int CLR = 2;
  localparam int TO  = 16;

  localparam int K_ABORT_CLEAR = 0;
  localparam int K_ABORT_KICK  = 1;
  localparam int K_DONE_S      = 2;
  localparam int K_DONE_F      = 3;
  localparam int K_BOTH        = 4;
  localparam int K_ABORT_RUN   = 5;
  localparam int K_ABORT_S     = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          abort = 1'b0;
  logic          grid_reset, grid_start;
  logic          grid_done_success = 1'b0;
  logic          grid_done_failure = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [CW-1:0] rsp_cycles;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_status_q[$];
  longint     exp_cycles_q[$];
  bit         force_hold = 1'b0;

  solve_sequencer #(
    .CYCLE_W        (CW),
    .CLEAR_CYCLES   (CLR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .abort             (abort),
    .grid_reset        (grid_reset),
    .grid_start        (grid_start),
    .grid_done_success (grid_done_success),
    .grid_done_failure (grid_done_failure),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_status        (rsp_status),
    .rsp_cycles        (rsp_cycles),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result of a solve from the scenario alone.
  task automatic model(input int kind, input int n, output logic [1:0] st, output longint cyc);
    longint sat;
    sat = (64'd1 << CW) - 1;
    case (kind)
      K_ABORT_CLEAR, K_ABORT_KICK: begin st = 2'd3; cyc = 0; end
      K_DONE_F:                    begin st = 2'd1; cyc = n; end
      K_ABORT_RUN:                 begin st = 2'd3; cyc = n; end
      default:                     begin st = 2'd0; cyc = n; end
    endcase
`ifdef SOLVE_TIMEOUT_EN
    if ((kind == K_ABORT_RUN && n >= TO) ||
        ((kind == K_DONE_S || kind == K_DONE_F || kind == K_BOTH || kind == K_ABORT_S) && n > TO)) begin
      st  = 2'd2;
      cyc = TO;
    end
`endif
    if (cyc > sat) cyc = sat;
  endtask

  task automatic wait_req_ready();
    int guard = 0;
    while (!req_ready && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    chk("req_ready_wait", req_ready, 1);
  endtask

  task automatic issue_req();
    wait_req_ready();
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Count from the first CLEAR cycle to the start pulse.
  task automatic wait_kick();
    int cnt = 1;
    while (!grid_start && cnt < 20) begin
      chk("clear_grid_reset", grid_reset, 1);
      @(negedge clock);
      cnt++;
    end
    chk("kick_latency", cnt, CLR + 1);
    chk("kick_grid_reset", grid_reset, 0);
  endtask

  task automatic run_txn(input int kind, input int n);
    logic [1:0] st;
    longint     cyc;
    model(kind, n, st, cyc);
    wait_req_ready();
    exp_status_q.push_back(st);
    exp_cycles_q.push_back(cyc);
    issue_req();
    if (kind == K_ABORT_CLEAR) begin
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      return;
    end
    wait_kick();
    if (kind == K_ABORT_KICK) begin
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      return;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      if (i == 1) begin
        chk("run_grid_start", grid_start, 0);
        chk("run_grid_reset", grid_reset, 0);
      end
    end
    grid_done_success = (kind == K_DONE_S || kind == K_BOTH || kind == K_ABORT_S);
    grid_done_failure = (kind == K_DONE_F || kind == K_BOTH);
    abort             = (kind == K_ABORT_RUN || kind == K_ABORT_S);
    @(negedge clock);
    grid_done_success = 1'b0;
    grid_done_failure = 1'b0;
    abort             = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on each new response, checks stability while held.
  initial begin
    bit         holding = 1'b0;
    bit         post_hs = 1'b0;
    int         hs_wait = 0;
    logic [1:0] held_s;
    logic [CW-1:0] held_c;
    forever begin
      @(negedge clock);
      if (post_hs) begin
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
        post_hs   = 1'b0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (!holding) begin
          if (exp_status_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got status=%0d cycles=%0d with no request pending", rsp_status, rsp_cycles);
          end else begin
            chk("rsp_status", rsp_status, exp_status_q.pop_front());
            chk("rsp_cycles", rsp_cycles, exp_cycles_q.pop_front());
          end
          held_s     = rsp_status;
          held_c     = rsp_cycles;
          holding    = 1'b1;
          hs_wait    = force_hold ? 3 : $urandom_range(0, 2);
          force_hold = 1'b0;
        end else begin
          chk("hold_status", rsp_status, held_s);
          chk("hold_cycles", rsp_cycles, held_c);
        end
        if (hs_wait == 0) begin
          rsp_ready = 1'b1;
          holding   = 1'b0;
          post_hs   = 1'b1;
        end else begin
          hs_wait--;
          rsp_ready = 1'b0;
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    #1;
    chk("rst_grid_reset", grid_reset, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_grid_reset", grid_reset, 1);
    chk("idle_grid_start", grid_start, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_status", rsp_status, 0);
    chk("idle_rsp_cycles", rsp_cycles, 0);

    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("idle_abort_ignored", busy, 0);

    force_hold = 1'b1;
    run_txn(K_DONE_S, 5);
    run_txn(K_DONE_F, 1);
    run_txn(K_ABORT_CLEAR, 0);
    run_txn(K_ABORT_KICK, 0);
    run_txn(K_ABORT_S, 4);
    run_txn(K_BOTH, 3);
    run_txn(K_ABORT_RUN, 40);
`ifdef SOLVE_TIMEOUT_EN
    run_txn(K_DONE_S, TO);
    run_txn(K_DONE_F, TO + 3);
`endif

    // Reset mid-RUN: immediate reset outputs, no response afterwards.
    wait_req_ready();
    issue_req();
    wait_kick();
    repeat (3) @(negedge clock);
    chk("midrun_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrun_rst_grid_reset", grid_reset, 1);
    chk("midrun_rst_rsp_valid", rsp_valid, 0);
    chk("midrun_rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);

    for (int t = 0; t < 30; t++) begin
      run_txn($urandom_range(0, 6), $urandom_range(1, 12));
    end

    guard = 0;
    while ((exp_status_q.size() != 0 || busy) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    chk("drain_pending", exp_status_q.size(), 0);
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
